hazard_stall_unit: RTL and testbench

//  Producer of the bubble-select consumed by the control-unit NOP mux: detects load-use and flag hazards for the ID stage.

---
 rtl/hazard_stall_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use / flag hazard detection, bubble control and operand forwarding for the ID stage.
// Optional saturating bubble counter on port stall_cnt when HAZ_STALL_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_use_flags,
    input  logic             id_rf_en,
    input  logic             id_load,
    input  logic             id_s,
    input  logic             branch_taken,
    output logic             nop_sel,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             ifid_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [3:0] rd;
        logic       rf_en;
        logic       load;
        logic       s;
    } shadow_t;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    localparam logic [2:0] LoadCnt = 3'(LOAD_STALL_CYCLES - 1);

    shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hz_load, hz_flag, hazard;
    logic       nop_core, clr_core;
    logic [1:0] sel_a, sel_b, sel_c;

    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input shadow_t ex,
                                           input shadow_t mem, input shadow_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 4'd15) begin
            if (ex.rf_en && ex.rd == src && ex.rd != 4'd15) begin
                sel = 2'b01;
            end else if (mem.rf_en && mem.rd == src && mem.rd != 4'd15) begin
                sel = 2'b10;
            end else if (wb.rf_en && wb.rd == src && wb.rd != 4'd15) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    always_comb begin
        hz_load = ex_q.load && ex_q.rf_en && (ex_q.rd != 4'd15) &&
                  ((id_use_rn && id_rn == ex_q.rd) ||
                   (id_use_rm && id_rm == ex_q.rd) ||
                   (id_use_rd && id_rd == ex_q.rd));
        hz_flag = id_use_flags && ex_q.s;
        hazard  = hz_load || hz_flag;
    end

    always_comb begin
        nop_core = 1'b0;
        clr_core = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StRun: begin
                if (hazard) begin
                    nop_core = 1'b1;
                    // A flag hazard needs only one bubble; load-use takes the configured count.
                    cnt_d    = hz_load ? LoadCnt : 3'd0;
                    state_d  = (cnt_d != 3'd0) ? StStall : StRun;
                end else if (branch_taken) begin
                    clr_core = 1'b1;
                end
            end
            StStall: begin
                nop_core = 1'b1;
                cnt_d    = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
                state_d  = (cnt_d == 3'd0) ? StRun : StStall;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        sel_a    = fwd_sel(id_rn, ex_q, mem_q, wb_q);
        sel_b    = fwd_sel(id_rm, ex_q, mem_q, wb_q);
        sel_c    = fwd_sel(id_rd, ex_q, mem_q, wb_q);
        nop_sel  = reset_n & nop_core;
        pc_ld    = ~nop_sel;
        ifid_ld  = ~nop_sel;
        ifid_clr = reset_n & clr_core;
        fwd_a    = reset_n ? sel_a : 2'b00;
        fwd_b    = reset_n ? sel_b : 2'b00;
        fwd_c    = reset_n ? sel_c : 2'b00;
    end

    always_comb begin
        ex_d  = nop_core ? '0 : {id_rd, id_rf_en, id_load, id_s};
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (nop_sel && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: vector table on a 1-bubble instance, hand sequences on a 3-bubble instance.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] id_rn, id_rm, id_rd;
    logic       id_use_rn, id_use_rm, id_use_rd, id_use_flags;
    logic       id_rf_en, id_load, id_s, branch_taken;

    logic       nop1, pcld1, ifld1, clr1;
    logic [1:0] fa1, fb1, fc1;
    logic       nop3, pcld3, ifld3, clr3;
    logic [1:0] fa3, fb3, fc3;
`ifdef HAZ_STALL_CNT_EN
    logic [15:0] scnt1, scnt3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_use_flags(id_use_flags), .id_rf_en(id_rf_en), .id_load(id_load), .id_s(id_s),
        .branch_taken(branch_taken), .nop_sel(nop1), .pc_ld(pcld1), .ifid_ld(ifld1),
        .ifid_clr(clr1), .fwd_a(fa1), .fwd_b(fb1), .fwd_c(fc1)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(scnt1)
`endif
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_use_flags(id_use_flags), .id_rf_en(id_rf_en), .id_load(id_load), .id_s(id_s),
        .branch_taken(branch_taken), .nop_sel(nop3), .pc_ld(pcld3), .ifid_ld(ifld3),
        .ifid_clr(clr3), .fwd_a(fa3), .fwd_b(fb3), .fwd_c(fc3)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(scnt3)
`endif
    );

    typedef struct {
        logic [3:0] rn, rm, rd;
        logic       urn, urm, urd, uf, rf, ld, s, br;
        logic       nop, clr;
        logic [1:0] fa, fb, fc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                                input logic urn, input logic urm, input logic urd,
                                input logic uf, input logic rf, input logic ld, input logic s,
                                input logic br, input logic nop, input logic clr,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [1:0] fc);
        vec_t v;
        v.rn = rn; v.rm = rm; v.rd = rd; v.urn = urn; v.urm = urm; v.urd = urd;
        v.uf = uf; v.rf = rf; v.ld = ld; v.s = s; v.br = br;
        v.nop = nop; v.clr = clr; v.fa = fa; v.fb = fb; v.fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rn = v.rn; id_rm = v.rm; id_rd = v.rd;
        id_use_rn = v.urn; id_use_rm = v.urm; id_use_rd = v.urd; id_use_flags = v.uf;
        id_rf_en = v.rf; id_load = v.ld; id_s = v.s; branch_taken = v.br;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        reset_n = 1'b1;
    endtask

    vec_t ldr_r2, str_r2;
    logic exp_nop[4];
    logic exp_clr[4];
    logic [1:0] exp_fc[4];

    initial begin
        //            rn  rm  rd urn urm urd uf rf ld s br | nop clr fa fb fc
        vecs[0]  = mk(0,  0,  1, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(1,  3,  2, 1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0);
        vecs[2]  = mk(1,  3,  2, 1, 1, 0, 0, 1, 0, 0, 0,  0, 0, 2, 0, 0);
        vecs[3]  = mk(6,  7,  1, 1, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 3);
        vecs[4]  = mk(5,  1,  4, 1, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        vecs[5]  = mk(5,  1,  4, 1, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 1);
        vecs[6]  = mk(1,  1,  8, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 3, 0);
        vecs[7]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        vecs[8]  = mk(4,  0,  3, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 3, 0, 0);
        vecs[9]  = mk(3,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0);
        vecs[10] = mk(3,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 0, 0);
        vecs[11] = mk(3,  0,  9, 1, 0, 0, 0, 1, 0, 1, 0,  0, 0, 3, 0, 0);
        vecs[12] = mk(0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[13] = mk(0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[14] = mk(0,  0, 15, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[15] = mk(15, 15, 15, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0,  0,  5, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[17] = mk(5,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);

        ldr_r2 = mk(0, 0, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        str_r2 = mk(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Outputs forced while reset is held, even with a taken branch presented.
        reset_n = 1'b0;
        drive(mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("rst_nop_sel", 16'(nop1), 16'd0);
        chk("rst_pc_ld", 16'(pcld1), 16'd1);
        chk("rst_ifid_ld", 16'(ifld1), 16'd1);
        chk("rst_ifid_clr", 16'(clr1), 16'd0);
        chk("rst_fwd", 16'({fa1, fb1, fc1}), 16'd0);
        tick();
        do_reset();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_nop_sel", i), 16'(nop1), 16'(vecs[i].nop));
            chk($sformatf("v%0d_pc_ld", i), 16'(pcld1), 16'(!vecs[i].nop));
            chk($sformatf("v%0d_ifid_ld", i), 16'(ifld1), 16'(!vecs[i].nop));
            chk($sformatf("v%0d_ifid_clr", i), 16'(clr1), 16'(vecs[i].clr));
            chk($sformatf("v%0d_fwd_a", i), 16'(fa1), 16'(vecs[i].fa));
            chk($sformatf("v%0d_fwd_b", i), 16'(fb1), 16'(vecs[i].fb));
            chk($sformatf("v%0d_fwd_c", i), 16'(fc1), 16'(vecs[i].fc));
            tick();
        end

        // Reset in the middle of a 3-bubble stall leaves no residual bubble.
        do_reset();
        drive(ldr_r2);
        tick();
        drive(str_r2);
        @(negedge clk);
        chk("mid_first_bubble", 16'(nop3), 16'd1);
        tick();
        @(negedge clk);
        chk("mid_second_bubble", 16'(nop3), 16'd1);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_nop_sel", 16'(nop3), 16'd0);
        chk("mid_rst_pc_ld", 16'(pcld3), 16'd1);
        chk("mid_rst_ifid_clr", 16'(clr3), 16'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_nop_sel", 16'(nop3), 16'd0);
        chk("post_rst_pc_ld", 16'(pcld3), 16'd1);
        chk("post_rst_fwd", 16'({fa3, fb3, fc3}), 16'd0);
`ifdef HAZ_STALL_CNT_EN
        chk("post_rst_stall_cnt", scnt3, 16'd0);
`endif
        tick();
        @(negedge clk);
        chk("post_rst_run", 16'(nop3), 16'd0);
        tick();

        // Full 3-bubble load-use into store data with a branch held in ID.
        do_reset();
        drive(ldr_r2);
        tick();
        drive(str_r2);
        exp_nop[0] = 1'b1; exp_clr[0] = 1'b0; exp_fc[0] = 2'b01;
        exp_nop[1] = 1'b1; exp_clr[1] = 1'b0; exp_fc[1] = 2'b10;
        exp_nop[2] = 1'b1; exp_clr[2] = 1'b0; exp_fc[2] = 2'b11;
        exp_nop[3] = 1'b0; exp_clr[3] = 1'b1; exp_fc[3] = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("s3_c%0d_nop_sel", c), 16'(nop3), 16'(exp_nop[c]));
            chk($sformatf("s3_c%0d_ifid_ld", c), 16'(ifld3), 16'(!exp_nop[c]));
            chk($sformatf("s3_c%0d_ifid_clr", c), 16'(clr3), 16'(exp_clr[c]));
            chk($sformatf("s3_c%0d_fwd_c", c), 16'(fc3), 16'(exp_fc[c]));
            tick();
        end
`ifdef HAZ_STALL_CNT_EN
        chk("s3_stall_cnt", scnt3, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
